// File: rtl/scarv_soc_intc_if.sv
// Request/response memory handshake shared by the SoC peripherals.
// The CPU-side bus is the master; the interrupt controller is the slave.
interface scarv_soc_intc_if;
    logic        mem_req;
    logic        mem_gnt;
    logic        mem_wen;
    logic [3:0]  mem_strb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_recv;
    logic        mem_ack;
    logic        mem_error;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_wen, mem_strb, mem_addr, mem_wdata, mem_ack,
        input  mem_gnt, mem_recv, mem_error, mem_rdata
    );

    modport slave (
        input  mem_req, mem_wen, mem_strb, mem_addr, mem_wdata, mem_ack,
        output mem_gnt, mem_recv, mem_error, mem_rdata
    );
endinterface

// File: rtl/scarv_soc_intc.sv
// External interrupt controller: synchronises, latches and masks NSRC sources,
// drives one request plus a cause code, and exposes a 16-byte register window.
module scarv_soc_intc #(
    parameter logic [31:0] BASE_ADDR = 32'h1000_2000,
    parameter int unsigned NSRC      = 8,
    parameter logic [31:0] EDGE_MASK = 32'h0000_0000
) (
    input  logic             f_clk,
    input  logic             g_reset,
    input  logic [NSRC-1:0]  irq_src,
    output logic             int_ext,
    output logic [31:0]      int_ext_cause,
    scarv_soc_intc_if.slave  mem
);
    localparam logic [NSRC-1:0] EDGE = EDGE_MASK[NSRC-1:0];

    typedef enum logic {IDLE, RESP} state_t;

    state_t          state_q, state_d;
    logic [NSRC-1:0] sync1_q, sync2_q, prev_q;
    logic [NSRC-1:0] pending_q, pending_d;
    logic [NSRC-1:0] enable_q, enable_d;
    logic            int_ext_q, int_ext_d;
    logic [31:0]     cause_q, cause_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            error_q, error_d;

    logic [NSRC-1:0] pending, active, edge_evt, claim_clr;
    logic [NSRC-1:0] sw_set, sw_clr;
    logic [31:0]     byte_mask, wbits, pend_ext, en_ext, low_idx;
    logic            any_active, access, in_window;
    logic [1:0]      reg_sel;
    logic            unused_bits;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_strb
            assign byte_mask[gi*8 +: 8] = {8{mem.mem_strb[gi]}};
        end
    endgenerate

    // Level sources are visible straight from the synchroniser; only edge
    // sources keep sticky state.
    assign pending    = (pending_q & EDGE) | (sync2_q & ~EDGE);
    assign active     = pending & enable_q;
    assign any_active = |active;
    assign edge_evt   = sync2_q & ~prev_q & EDGE;
    assign claim_clr  = active & ~(active - NSRC'(1));

    assign wbits     = mem.mem_wdata & byte_mask;
    assign in_window = (mem.mem_addr[31:4] == BASE_ADDR[31:4]);
    assign reg_sel   = mem.mem_addr[3:2];

    assign mem.mem_gnt   = (state_q == IDLE) && mem.mem_req && !g_reset;
    assign access        = mem.mem_req && mem.mem_gnt;
    assign mem.mem_recv  = (state_q == RESP);
    assign mem.mem_error = error_q;
    assign mem.mem_rdata = rdata_q;
    assign int_ext       = int_ext_q;
    assign int_ext_cause = cause_q;

    assign unused_bits = ^{mem.mem_addr[1:0], wbits, byte_mask};

    always_comb begin
        low_idx = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (active[i]) low_idx = i[31:0];
        end
        pend_ext = '0;
        pend_ext[NSRC-1:0] = pending;
        en_ext = '0;
        en_ext[NSRC-1:0] = enable_q;
    end

    always_comb begin
        state_d  = state_q;
        rdata_d  = rdata_q;
        error_d  = error_q;
        enable_d = enable_q;
        sw_set   = '0;
        sw_clr   = '0;
        case (state_q)
            IDLE: begin
                if (access) begin
                    state_d = RESP;
                    rdata_d = '0;
                    error_d = !in_window;
                    if (in_window && mem.mem_wen) begin
                        case (reg_sel)
                            2'd0:    sw_clr   = wbits[NSRC-1:0];
                            2'd1:    enable_d = (enable_q & ~byte_mask[NSRC-1:0]) | wbits[NSRC-1:0];
                            2'd3:    sw_set   = wbits[NSRC-1:0];
                            default: ;
                        endcase
                    end else if (in_window) begin
                        case (reg_sel)
                            2'd0:    rdata_d = pend_ext;
                            2'd1:    rdata_d = en_ext;
                            2'd2:    rdata_d = any_active ? (low_idx | 32'h8000_0000) : 32'h0;
                            default: rdata_d = 32'h0;
                        endcase
                    end
                end
            end
            RESP: begin
                if (mem.mem_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A claim clears only when it is the read actually being performed; a
    // coincident set (edge event or SWSET) still wins over any clear.
    always_comb begin
        pending_d = EDGE & ((pending_q &
                    ~(sw_clr | ((access && in_window && !mem.mem_wen && reg_sel == 2'd2)
                                ? claim_clr : '0)))
                    | sw_set | edge_evt);
        int_ext_d = any_active;
        cause_d   = any_active ? low_idx : cause_q;
    end

    always_ff @(posedge f_clk or posedge g_reset) begin
        if (g_reset) begin
            state_q   <= IDLE;
            sync1_q   <= '0;
            sync2_q   <= '0;
            prev_q    <= '0;
            pending_q <= '0;
            enable_q  <= '0;
            int_ext_q <= 1'b0;
            cause_q   <= '0;
            rdata_q   <= '0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= irq_src;
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
            pending_q <= pending_d;
            enable_q  <= enable_d;
            int_ext_q <= int_ext_d;
            cause_q   <= cause_d;
            rdata_q   <= rdata_d;
            error_q   <= error_d;
        end
    end
endmodule

// File: tb/tb_scarv_soc_intc.sv
// Bench for scarv_soc_intc: directed scenarios plus random bus/irq traffic,
// every cycle compared against a pin-history reference model.
module tb_scarv_soc_intc;
    localparam logic [31:0] BASE      = 32'h1000_2000;
    localparam int          NSRC      = 8;
    localparam logic [31:0] EDGE_MASK = 32'h0000_0037;
    localparam logic [7:0]  EDGE      = 8'h37;

    logic            f_clk = 1'b0;
    logic            g_reset;
    logic [NSRC-1:0] irq_src, irq_dir, irq_rand;
    bit              rand_on = 1'b0;
    logic            int_ext;
    logic [31:0]     int_ext_cause;

    scarv_soc_intc_if bus ();

    scarv_soc_intc #(.BASE_ADDR(BASE), .NSRC(NSRC), .EDGE_MASK(EDGE_MASK)) dut (
        .f_clk(f_clk), .g_reset(g_reset), .irq_src(irq_src), .int_ext(int_ext),
        .int_ext_cause(int_ext_cause), .mem(bus)
    );

    assign irq_src = rand_on ? irq_rand : irq_dir;

    always #5 f_clk = ~f_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: pin history s[k-1..k-3], edge-source pending set, enable.
    logic [NSRC-1:0] hist [0:2] = '{8'h0, 8'h0, 8'h0};
    logic [NSRC-1:0] m_pend = '0, m_en = '0;
    logic            m_int = 1'b0, m_err = 1'b0, m_resp = 1'b0;
    logic [31:0]     m_cause = '0, m_rdata = '0;

    function automatic int lowest(input logic [NSRC-1:0] v);
        int idx = -1;
        for (int i = 0; i < NSRC; i++) if (v[i] && idx < 0) idx = i;
        return idx;
    endfunction

    task automatic model_step();
        logic [NSRC-1:0] vis, act, clr, set, wv, bm;
        logic [31:0]     bm32;
        int lo, r;
        if (g_reset) begin
            m_pend = '0; m_en = '0; m_int = 1'b0; m_cause = '0;
            m_rdata = '0; m_err = 1'b0; m_resp = 1'b0;
            hist[0] = '0; hist[1] = '0; hist[2] = '0;
        end else begin
            vis = (m_pend & EDGE) | (hist[1] & ~EDGE);
            act = vis & m_en;
            lo  = lowest(act);
            clr = '0;
            set = hist[1] & ~hist[2] & EDGE;
            if (m_resp) begin
                if (bus.mem_ack) m_resp = 1'b0;
            end else if (bus.mem_req) begin
                m_resp  = 1'b1;
                m_rdata = '0;
                m_err   = (bus.mem_addr[31:4] != BASE[31:4]);
                for (int b = 0; b < 4; b++) bm32[b*8 +: 8] = {8{bus.mem_strb[b]}};
                bm = bm32[NSRC-1:0];
                wv = bus.mem_wdata[NSRC-1:0] & bm;
                r  = int'(bus.mem_addr % 16) / 4;
                if (!m_err && bus.mem_wen) begin
                    if (r == 0) clr = wv & EDGE;
                    if (r == 1) m_en = (m_en & ~bm) | wv;
                    if (r == 3) set = set | (wv & EDGE);
                end else if (!m_err) begin
                    if (r == 0) m_rdata = 32'(vis);
                    if (r == 1) m_rdata = 32'(m_en);
                    if (r == 2 && lo >= 0) begin
                        m_rdata = 32'h8000_0000 + 32'(lo);
                        clr[lo] = EDGE[lo];
                    end
                end
            end
            m_int = (act != '0);
            if (lo >= 0) m_cause = 32'(lo);
            m_pend = ((m_pend & ~clr) | set) & EDGE;
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = irq_src;
        end
    endtask

    initial forever begin
        @(posedge f_clk);
        model_step();
    end

    initial forever begin
        @(negedge f_clk);
        #1;
        check_eq("int_ext", 32'(int_ext), g_reset ? 32'd0 : 32'(m_int));
        check_eq("cause", int_ext_cause, g_reset ? 32'd0 : m_cause);
        check_eq("recv", 32'(bus.mem_recv), g_reset ? 32'd0 : 32'(m_resp));
        check_eq("gnt", 32'(bus.mem_gnt), 32'(bus.mem_req && !m_resp && !g_reset));
        if (m_resp && !g_reset) begin
            check_eq("rdata", bus.mem_rdata, m_rdata);
            check_eq("error", 32'(bus.mem_error), 32'(m_err));
        end
    end

    initial forever begin
        @(negedge f_clk);
        if (rand_on) irq_rand = irq_rand ^ NSRC'($urandom & $urandom & $urandom);
    end

    // Called at a negedge; returns at the negedge after the acknowledged response.
    task automatic xfer(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input int ack_wait, input bit hold_req,
                        output logic [31:0] rdata, output logic err);
        int cyc;
        bus.mem_req = 1'b1; bus.mem_wen = wen; bus.mem_addr = addr;
        bus.mem_wdata = wdata; bus.mem_strb = strb; bus.mem_ack = 1'b0;
        #1;
        cyc = 0;
        while (bus.mem_gnt !== 1'b1 && cyc < 8) begin
            @(negedge f_clk); #1; cyc++;
        end
        check_eq("gnt_seen", 32'(bus.mem_gnt), 32'd1);
        @(posedge f_clk);
        @(negedge f_clk);
        if (!hold_req) bus.mem_req = 1'b0;
        check_eq("recv_latency", 32'(bus.mem_recv), 32'd1);
        repeat (ack_wait) @(negedge f_clk);
        rdata = bus.mem_rdata;
        err   = bus.mem_error;
        bus.mem_ack = 1'b1;
        @(posedge f_clk);
        @(negedge f_clk);
        bus.mem_ack = 1'b0;
        bus.mem_req = 1'b0;
        $display("xfer %s addr=%08h wdata=%08h strb=%h rdata=%08h err=%0d",
                 wen ? "WR" : "RD", addr, wdata, strb, rdata, err);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        g_reset = 1'b1; irq_dir = '0; irq_rand = '0;
        bus.mem_req = 1'b0; bus.mem_wen = 1'b0; bus.mem_strb = 4'h0;
        bus.mem_addr = '0; bus.mem_wdata = '0; bus.mem_ack = 1'b0;
        repeat (3) @(negedge f_clk);
        g_reset = 1'b0;
        @(negedge f_clk);
        check_eq("rst_int_ext", 32'(int_ext), 32'd0);
        check_eq("rst_cause", int_ext_cause, 32'd0);
        check_eq("rst_rdata", bus.mem_rdata, 32'd0);
        check_eq("rst_error", 32'(bus.mem_error), 32'd0);
        for (int r = 0; r < 4; r++) begin
            xfer(1'b0, BASE + 32'(r * 4), 32'h0, 4'hf, 0, 1'b0, rd, er);
            check_eq("rst_read", rd, 32'd0);
            check_eq("rst_read_err", 32'(er), 32'd0);
        end

        // Edge source 0: one-cycle pulse, 3-cycle latency, claim clears it.
        xfer(1'b1, BASE + 32'h4, 32'h1, 4'hf, 0, 1'b0, rd, er);
        irq_dir[0] = 1'b1;
        @(negedge f_clk); irq_dir[0] = 1'b0;
        @(negedge f_clk);
        @(negedge f_clk); #1;
        check_eq("edge_int_early", 32'(int_ext), 32'd0);
        @(negedge f_clk);
        check_eq("edge_int", 32'(int_ext), 32'd1);
        xfer(1'b0, BASE + 32'h8, 32'h0, 4'hf, 0, 1'b0, rd, er);
        check_eq("claim0", rd, 32'h8000_0000);
        check_eq("claim_int_fall", 32'(int_ext), 32'd0);
        xfer(1'b0, BASE + 32'h8, 32'h0, 4'hf, 0, 1'b0, rd, er);
        check_eq("claim_empty", rd, 32'h0);

        // Level source 3: W1C ignored, release visible 3 cycles later.
        xfer(1'b1, BASE + 32'h4, 32'h08, 4'hf, 0, 1'b0, rd, er);
        irq_dir[3] = 1'b1;
        repeat (4) @(negedge f_clk);
        check_eq("lvl_int", 32'(int_ext), 32'd1);
        check_eq("lvl_cause", int_ext_cause, 32'd3);
        xfer(1'b1, BASE + 32'h0, 32'h08, 4'hf, 0, 1'b0, rd, er);
        xfer(1'b0, BASE + 32'h0, 32'h0, 4'hf, 0, 1'b0, rd, er);
        check_eq("lvl_w1c_ignored", rd, 32'h08);
        irq_dir[3] = 1'b0;
        @(negedge f_clk);
        @(negedge f_clk);
        check_eq("lvl_hold", 32'(int_ext), 32'd1);
        @(negedge f_clk);
        check_eq("lvl_release", 32'(int_ext), 32'd0);

        // Priority between sources 2 and 5.
        xfer(1'b1, BASE + 32'hC, 32'h24, 4'hf, 0, 1'b0, rd, er);
        xfer(1'b1, BASE + 32'h4, 32'h24, 4'hf, 0, 1'b0, rd, er);
        check_eq("prio_cause2", int_ext_cause, 32'd2);
        xfer(1'b1, BASE + 32'h4, 32'h20, 4'hf, 0, 1'b0, rd, er);
        check_eq("prio_cause5", int_ext_cause, 32'd5);
        xfer(1'b1, BASE + 32'h0, 32'h24, 4'hf, 0, 1'b0, rd, er);
        xfer(1'b0, BASE + 32'h0, 32'h0, 4'hf, 0, 1'b0, rd, er);
        check_eq("prio_cleared", rd, 32'h0);

        // Edge event on source 1 coincides with a W1C of the same bit.
        irq_dir[1] = 1'b1;
        @(negedge f_clk);
        @(negedge f_clk);
        xfer(1'b1, BASE + 32'h0, 32'h02, 4'hf, 0, 1'b0, rd, er);
        xfer(1'b0, BASE + 32'h0, 32'h0, 4'hf, 0, 1'b0, rd, er);
        check_eq("set_wins", rd, 32'h02);
        irq_dir[1] = 1'b0;
        xfer(1'b1, BASE + 32'h0, 32'h02, 4'hf, 0, 1'b0, rd, er);
        xfer(1'b0, BASE + 32'h0, 32'h0, 4'hf, 0, 1'b0, rd, er);
        check_eq("w1c_clears", rd, 32'h0);

        // Out-of-window read with a stalled acknowledge and request held high.
        xfer(1'b0, BASE + 32'h10, 32'h0, 4'hf, 4, 1'b1, rd, er);
        check_eq("oow_rdata", rd, 32'h0);
        check_eq("oow_error", 32'(er), 32'd1);

        // Reset while a response is outstanding abandons it.
        bus.mem_req = 1'b1; bus.mem_wen = 1'b0; bus.mem_addr = BASE + 32'h4;
        @(posedge f_clk);
        @(negedge f_clk);
        bus.mem_req = 1'b0;
        check_eq("resp_before_rst", 32'(bus.mem_recv), 32'd1);
        #2 g_reset = 1'b1;
        #1 check_eq("rst_in_resp", 32'(bus.mem_recv), 32'd0);
        @(negedge f_clk);
        @(negedge f_clk);
        g_reset = 1'b0;
        @(negedge f_clk);
        check_eq("no_resp_after_rst", 32'(bus.mem_recv), 32'd0);
        xfer(1'b0, BASE + 32'h4, 32'h0, 4'hf, 0, 1'b0, rd, er);
        check_eq("enable_after_rst", rd, 32'h0);

        // Random traffic against the model.
        rand_on = 1'b1;
        for (int t = 0; t < 250; t++) begin
            logic [31:0] addr;
            addr = ($urandom_range(0, 9) == 0) ? $urandom : BASE + 32'($urandom_range(0, 15));
            repeat ($urandom_range(0, 2)) @(negedge f_clk);
            xfer(1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)),
                 int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), rd, er);
        end
        rand_on = 1'b0;
        repeat (5) @(negedge f_clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
